// File: rtl/whac_pkg.sv
// whac_pkg: shared game-state type, score-word limits and hit-points multiplier function
package whac_pkg;
  typedef enum logic [1:0] {IDLE, PLAYING, GAME_OVER} game_state_t;
  localparam int unsigned SCORE_INC_W = 7;
  localparam int unsigned SCORE_INC_MAX = 99;
  function automatic logic [SCORE_INC_W-1:0] mult_pts(input int unsigned combo, input int unsigned base,
                                                      input int unsigned step, input int unsigned max_mult);
    int unsigned mult;
    int unsigned prod;
    mult = 1 + combo / step;
    mult = mult > max_mult ? max_mult : mult;
    prod = base * mult;
    return prod > SCORE_INC_MAX ? SCORE_INC_W'(SCORE_INC_MAX) : SCORE_INC_W'(prod);
  endfunction
endpackage

// File: rtl/game_timer.sv
// game_timer: loadable round down-counter; load restarts at LOAD, dec counts down stopping at zero, zero flags expiry
module game_timer #(
  parameter int LOAD = 60,
  localparam int W = $clog2(LOAD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  always_ff @(posedge clk)
    if (rst || load) count <= W'(LOAD);
    else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/score_controller.sv
// score_controller: whac-a-mole game FSM, round countdown and combo scoring; in clk/rst/start/tick/hit/miss, out score_increase/score_rst/combo_count/time_left/game_active/game_over
module score_controller
  import whac_pkg::*;
#(
  parameter int GAME_SECONDS = 60,
  parameter int BASE_POINTS = 10,
  parameter int COMBO_STEP = 5,
  parameter int MAX_MULT = 5,
  parameter int COMBO_WIDTH = 7,
  localparam int TW = $clog2(GAME_SECONDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   tick,
  input  logic                   hit,
  input  logic                   miss,
  output logic [SCORE_INC_W-1:0] score_increase,
  output logic                   score_rst,
  output logic [COMBO_WIDTH-1:0] combo_count,
  output logic [TW-1:0]          time_left,
  output logic                   game_active,
  output logic                   game_over
);
  game_state_t r_state, w_next;
  logic [SCORE_INC_W-1:0] r_inc, w_inc;
  logic [COMBO_WIDTH-1:0] r_combo, w_combo;
  logic r_srst;
  logic w_play, w_start_ok, w_zero;
  assign w_play = r_state == PLAYING;
  assign w_start_ok = start && !w_play;
  game_timer #(.LOAD(GAME_SECONDS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_start_ok),
    .dec  (tick && w_play),
    .count(time_left),
    .zero (w_zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_inc <= '0;
      r_combo <= '0;
      r_srst <= 1'b0;
    end else begin
      r_state <= w_next;
      r_inc <= w_inc;
      r_combo <= w_combo;
      r_srst <= w_start_ok;
    end
  always_comb
    w_next = w_start_ok ? PLAYING :
             (w_play && ((tick && time_left == TW'(1)) || w_zero)) ? GAME_OVER : r_state;
  // a hit beats a simultaneous miss; outside PLAYING the streak is frozen until the next start clears it
  always_comb begin
    w_inc = (w_play && hit) ? mult_pts(32'(r_combo), BASE_POINTS, COMBO_STEP, MAX_MULT) : '0;
    w_combo = w_start_ok ? '0 :
              !w_play ? r_combo :
              hit ? (&r_combo ? r_combo : r_combo + 1'b1) :
              miss ? '0 : r_combo;
  end
  assign score_increase = r_inc;
  assign score_rst = r_srst;
  assign combo_count = r_combo;
  assign game_active = w_play;
  assign game_over = r_state == GAME_OVER;
endmodule

// File: tb/tb_score_controller.sv
// tb_score_controller: directed stimulus with a queued scoreboard of expected points words checked by a monitor
module tb_score_controller;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tick = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [6:0] score_increase;
  logic score_rst, game_active, game_over;
  logic [6:0] combo_count;
  logic [5:0] time_left;
  typedef struct {int cyc; int pts;} exp_t;
  exp_t q[$];
  int cyc = 0, n_vec = 0, n_err = 0;

  score_controller dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .hit(hit), .miss(miss),
    .score_increase(score_increase), .score_rst(score_rst), .combo_count(combo_count),
    .time_left(time_left), .game_active(game_active), .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (score_increase != 0) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_points cyc=%0d got %0d expected 0", cyc, score_increase);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.pts != int'(score_increase)) begin
          n_err++;
          $display("FAIL points cyc=%0d got %0d expected %0d at cyc %0d", cyc, score_increase, e.pts, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_points cyc=%0d got 0 expected %0d", cyc, e.pts);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic t, input logic h, input logic m, input int pts);
    @(negedge clk);
    start = s; tick = t; hit = h; miss = m;
    if (pts >= 0) q.push_back('{cyc + 1, pts});
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, -1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_inc"}, score_increase, 0);
    chk({tag, "_srst"}, score_rst, 0);
    chk({tag, "_combo"}, combo_count, 0);
    chk({tag, "_time"}, time_left, 60);
    chk({tag, "_active"}, game_active, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  task automatic new_game(input string tag);
    drive(1, 0, 0, 0, -1);
    idle();
    chk({tag, "_srst_hi"}, score_rst, 1);
    chk({tag, "_time60"}, time_left, 60);
    chk({tag, "_combo0"}, combo_count, 0);
    chk({tag, "_active"}, game_active, 1);
    idle();
    chk({tag, "_srst_lo"}, score_rst, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
    drive(0, 1, 1, 0, -1);
    idle();
    chk("idle_hit_ignored", combo_count, 0);
    chk("idle_tick_ignored", time_left, 60);
    new_game("start1");
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, i == 5 ? 20 : 10);
      idle();
      idle();
    end
    chk("six_hits_combo", combo_count, 6);
    drive(0, 0, 0, 1, -1);
    idle();
    chk("miss_clears", combo_count, 0);
    for (int k = 0; k < 12; k++) drive(0, 0, 1, 0, k < 5 ? 10 : (k < 10 ? 20 : 30));
    drive(0, 0, 0, 1, -1);
    idle();
    chk("combo_after_miss", combo_count, 0);
    drive(0, 0, 1, 0, 10);
    idle();
    chk("combo_after_rehit", combo_count, 1);
    drive(0, 0, 0, 1, -1);
    for (int k = 0; k < 30; k++) drive(0, 0, 1, 0, (k / 5 + 1) > 5 ? 50 : 10 * (k / 5 + 1));
    idle();
    chk("thirty_hits_combo", combo_count, 30);
    drive(0, 0, 0, 1, -1);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 0, 10);
    drive(0, 0, 1, 1, 10);
    idle();
    chk("hit_miss_combo", combo_count, 5);
    drive(1, 0, 0, 0, -1);
    idle();
    chk("start_ignored_playing", score_rst, 0);
    chk("start_keeps_combo", combo_count, 5);
    drive(0, 0, 0, 1, -1);
    for (int k = 0; k < 7; k++) drive(0, 1, 1, 0, k < 5 ? 10 : 20);
    for (int k = 0; k < 23; k++) drive(0, 1, 0, 0, -1);
    idle();
    chk("pre_rst_time", time_left, 30);
    chk("pre_rst_combo", combo_count, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    drive(0, 0, 1, 0, -1);
    idle();
    chk("post_rst_hit_ignored", combo_count, 0);
    new_game("start2");
    for (int k = 0; k < 59; k++) drive(0, 1, 0, 0, -1);
    idle();
    chk("time_at_1", time_left, 1);
    drive(0, 1, 1, 0, 10);
    idle();
    chk("final_over", game_over, 1);
    chk("final_time0", time_left, 0);
    chk("final_inactive", game_active, 0);
    drive(0, 1, 1, 0, -1);
    idle();
    chk("over_combo_held", combo_count, 1);
    chk("over_tick_ignored", time_left, 0);
    drive(1, 0, 1, 0, -1);
    idle();
    chk("restart_srst", score_rst, 1);
    chk("restart_time", time_left, 60);
    chk("restart_combo", combo_count, 0);
    chk("restart_active", game_active, 1);
    repeat (3) idle();
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
